// File: rtl/router_image_pkg.sv
// Shared definitions for the routing-table image format,
// used by both the image writer and the table loader.
package router_image_pkg;

    localparam logic [31:0] DEST_MAGIC          = 32'h44455354;
    localparam logic [31:0] TERM_WORD           = 32'h00000000;
    localparam int          HEADER_WORDS        = 4;
    localparam int          ENTRY_WORDS         = 8;
    localparam int          ENTRY_BYTES         = 32;
    localparam int          HEADER_BYTES        = 16;
    localparam int          MAX_ENTRIES_DEFAULT = 64;

    // Field positions inside one 256-bit table entry
    localparam int ENT_DLID_LSB   = 0;
    localparam int ENT_DLID_W     = 16;
    localparam int ENT_PORT_LSB   = 16;
    localparam int ENT_PORT_W     = 8;
    localparam int ENT_VL_LSB     = 24;
    localparam int ENT_VL_W       = 4;
    localparam int ENT_FLAGS_LSB  = 28;
    localparam int ENT_FLAGS_W    = 4;
    localparam int ENT_COST_LSB   = 32;
    localparam int ENT_COST_W     = 16;
    localparam int ENT_HOPS_LSB   = 48;
    localparam int ENT_HOPS_W     = 8;
    localparam int ENT_PATH_LSB   = 64;
    localparam int ENT_PATH_W     = 192;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_HDR,
        ST_REQ_ENTRY,
        ST_WAIT_ENTRY,
        ST_WR_ENTRY,
        ST_TERM,
        ST_DONE,
        ST_ERROR
    } wr_state_e;

    // Header word by position: magic, count, owner, reserved
    function automatic logic [31:0] hdr_word(
        input logic [1:0] idx,
        input logic [6:0] n,
        input logic [3:0] sid
    );
        logic [31:0] w;
        unique case (idx)
            2'd0:    w = DEST_MAGIC;
            2'd1:    w = {25'd0, n};
            2'd2:    w = {28'd0, sid};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Word k of an entry, little word first
    function automatic logic [31:0] entry_word(
        input logic [255:0] e,
        input logic [2:0]   k
    );
        return e[32*k +: 32];
    endfunction

endpackage

// File: rtl/router_writer.sv
// Serializes one switch routing table into a header + entries +
// terminator image written word by word into the image RAM.
module router_writer
    import router_image_pkg::*;
#(
    parameter int MAX_ENTRIES = MAX_ENTRIES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_write,
    input  logic [3:0]   switch_id,
    input  logic [6:0]   entry_count,
    input  logic [31:0]  base_addr,
    output logic         tbl_rd_en,
    output logic [5:0]   tbl_rd_addr,
    input  logic [255:0] tbl_rd_data,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         mem_we,
    input  logic         mem_ready,
    output logic         busy,
    output logic         write_done,
    output logic         write_error,
    output logic [31:0]  next_addr
);

    wr_state_e      state_q, state_d;
    logic [3:0]     sid_q, sid_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [31:0]    base_q, base_d;
    logic [6:0]     idx_q, idx_d;
    logic [2:0]     wcnt_q, wcnt_d;
    logic [255:0]   buf_q, buf_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic           mem_we_q, mem_we_d;
    logic           tbl_rd_en_q, tbl_rd_en_d;
    logic [5:0]     tbl_rd_addr_q, tbl_rd_addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [31:0]    next_addr_q, next_addr_d;

    logic           accept;
    logic           last_acc;
    logic           bad_req;

    assign accept  = mem_we_q && mem_ready;
    assign bad_req = ({25'd0, cnt_q} > 32'(MAX_ENTRIES))
                     || (base_q[1:0] != 2'b00);

    // Next-state and next-output logic; addresses advance one word per accept
    always_comb begin
        state_d       = state_q;
        sid_d         = sid_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        idx_d         = idx_q;
        wcnt_d        = wcnt_q;
        buf_d         = buf_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        tbl_rd_en_d   = 1'b0;
        tbl_rd_addr_d = tbl_rd_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        next_addr_d   = next_addr_q;
        last_acc      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_write) begin
                    sid_d   = switch_id;
                    cnt_d   = entry_count;
                    base_d  = base_addr;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bad_req) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    idx_d       = 7'd0;
                    wcnt_d      = 3'd0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q;
                    mem_wdata_d = DEST_MAGIC;
                    state_d     = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (wcnt_q == 3'(HEADER_WORDS - 1)) begin
                        last_acc = 1'b1;
                    end else begin
                        wcnt_d      = wcnt_q + 3'd1;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wdata_d = hdr_word(wcnt_q[1:0] + 2'd1,
                                               cnt_q, sid_q);
                    end
                end
            end
            ST_REQ_ENTRY: begin
                state_d = ST_WAIT_ENTRY;
            end
            ST_WAIT_ENTRY: begin
                buf_d       = tbl_rd_data;
                wcnt_d      = 3'd0;
                mem_we_d    = 1'b1;
                mem_wdata_d = entry_word(tbl_rd_data, 3'd0);
                state_d     = ST_WR_ENTRY;
            end
            ST_WR_ENTRY: begin
                if (accept) begin
                    if (wcnt_q == 3'(ENTRY_WORDS - 1)) begin
                        idx_d    = idx_q + 7'd1;
                        last_acc = 1'b1;
                    end else begin
                        wcnt_d      = wcnt_q + 3'd1;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wdata_d = entry_word(buf_q, wcnt_q + 3'd1);
                    end
                end
            end
            ST_TERM: begin
                if (accept) begin
                    mem_we_d    = 1'b0;
                    next_addr_d = mem_addr_q;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // After a block's last word: either fetch the next entry or finish
        if (last_acc) begin
            mem_we_d   = 1'b0;
            mem_addr_d = mem_addr_q + 32'd4;
            if (idx_d == cnt_q) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = TERM_WORD;
                state_d     = ST_TERM;
            end else begin
                tbl_rd_en_d   = 1'b1;
                tbl_rd_addr_d = idx_d[5:0];
                state_d       = ST_REQ_ENTRY;
            end
        end
    end

    // State and registered outputs; reset aborts any write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sid_q         <= '0;
            cnt_q         <= '0;
            base_q        <= '0;
            idx_q         <= '0;
            wcnt_q        <= '0;
            buf_q         <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            tbl_rd_en_q   <= 1'b0;
            tbl_rd_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            next_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            sid_q         <= sid_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            idx_q         <= idx_d;
            wcnt_q        <= wcnt_d;
            buf_q         <= buf_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            tbl_rd_en_q   <= tbl_rd_en_d;
            tbl_rd_addr_q <= tbl_rd_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            next_addr_q   <= next_addr_d;
        end
    end

    assign tbl_rd_en   = tbl_rd_en_q;
    assign tbl_rd_addr = tbl_rd_addr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign busy        = busy_q;
    assign write_done  = done_q;
    assign write_error = err_q;
    assign next_addr   = next_addr_q;

endmodule

// File: tb/tb_router_writer.sv
// Directed bench for router_writer: image content, cycle timing,
// stalls, rejects, chaining and mid-write reset.
module tb_router_writer;

    logic         clk;
    logic         rst_n;
    logic         start_write;
    logic [3:0]   switch_id;
    logic [6:0]   entry_count;
    logic [31:0]  base_addr;
    logic         tbl_rd_en;
    logic [5:0]   tbl_rd_addr;
    logic [255:0] tbl_rd_data;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic         mem_ready;
    logic         busy;
    logic         write_done;
    logic         write_error;
    logic [31:0]  next_addr;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t          wlog[$];
    logic [31:0]  mem [0:1023];
    logic [255:0] tbl [0:63];

    int checks;
    int errors;

    router_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_write (start_write),
        .switch_id   (switch_id),
        .entry_count (entry_count),
        .base_addr   (base_addr),
        .tbl_rd_en   (tbl_rd_en),
        .tbl_rd_addr (tbl_rd_addr),
        .tbl_rd_data (tbl_rd_data),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .write_done  (write_done),
        .write_error (write_error),
        .next_addr   (next_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Routing engine read port: data valid only the cycle after a strobe
    always @(posedge clk) begin
        if (tbl_rd_en) tbl_rd_data <= tbl[tbl_rd_addr];
        else           tbl_rd_data <= {8{32'hBAD0BAD0}};
    end

    // Image RAM model: records every accepted write in order
    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            wlog.push_back('{mem_addr, mem_wdata});
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] salt);
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 8; k++)
                tbl[i][32*k +: 32] = {salt, 8'(i), 8'(k), 8'h5A};
    endtask

    // One table write; returns cycle offsets from the start-sample cycle T
    task automatic run(input logic [3:0] sid, input logic [6:0] n,
                       input logic [31:0] base,
                       input logic [31:0] sa0, input int sl0,
                       input logic [31:0] sa1, input int sl1,
                       output int done_k, output int err_k,
                       output int idle_k, output int rd_first,
                       output int rd_n, output int we_n);
        int k;
        int l0;
        int l1;
        logic stl;
        logic [31:0] pa;
        logic [31:0] pd;
        done_k = -1; err_k = -1; rd_first = -1;
        rd_n = 0; we_n = 0; stl = 1'b0; pa = '0; pd = '0;
        l0 = sl0; l1 = sl1;
        @(negedge clk);
        switch_id = sid; entry_count = n; base_addr = base;
        start_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_write = 1'b0;
        switch_id = 4'hF; entry_count = 7'h7F; base_addr = '1;
        k = 1;
        while (k < 3000) begin
            if (stl) begin
                chk("stall_we_addr", {31'd0, mem_we, mem_addr},
                    {31'd0, 1'b1, pa});
                chk("stall_data", {32'd0, mem_wdata}, {32'd0, pd});
            end
            if (write_done)  done_k = k;
            if (write_error) err_k = k;
            if (tbl_rd_en) begin
                rd_n++;
                if (rd_first < 0) rd_first = k;
            end
            if (mem_we) we_n++;
            if (!busy) break;
            mem_ready = 1'b1;
            if (mem_we && l0 > 0 && mem_addr == sa0) begin
                mem_ready = 1'b0; l0--;
            end else if (mem_we && l1 > 0 && mem_addr == sa1) begin
                mem_ready = 1'b0; l1--;
            end
            stl = mem_we && !mem_ready;
            pa = mem_addr; pd = mem_wdata;
            @(negedge clk);
            k++;
        end
        mem_ready = 1'b1;
        idle_k = k;
        chk("busy_bound", {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_image(input int idx0, input logic [3:0] sid,
                             input logic [6:0] n, input logic [31:0] base);
        int m;
        int tot;
        int e;
        int w;
        logic [31:0] ea;
        logic [31:0] ed;
        tot = 5 + 8 * int'(n);
        m = wlog.size() - idx0;
        chk("n_writes", 64'(m), 64'(tot));
        for (int j = 0; j < tot && j < m; j++) begin
            ea = base + 32'(4 * j);
            if (j == 0)                   ed = 32'h44455354;
            else if (j == 1)              ed = {25'd0, n};
            else if (j == 2)              ed = {28'd0, sid};
            else if (j == 3 || j == tot-1) ed = 32'd0;
            else begin
                e = (j - 4) / 8;
                w = (j - 4) % 8;
                ed = tbl[e][32*w +: 32];
            end
            chk("wr_addr", {32'd0, wlog[idx0+j].a}, {32'd0, ea});
            chk("wr_data", {32'd0, wlog[idx0+j].d}, {32'd0, ed});
        end
    endtask

    int d_k, e_k, i_k, r_f, r_n, w_n, idx0, p, cnt, found;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start_write = 1'b0; switch_id = '0;
        entry_count = '0; base_addr = '0; mem_ready = 1'b1;
        fill(8'h11);
        repeat (3) @(negedge clk);
        chk("rst_we", {63'd0, mem_we}, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_done_err", {62'd0, write_done, write_error}, 0);
        chk("rst_rd_en", {63'd0, tbl_rd_en}, 0);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 0);
        chk("rst_next", {32'd0, next_addr}, 0);
        rst_n = 1'b1;

        // N=2, id 3, base 0, no stalls
        idx0 = wlog.size();
        run(4'd3, 7'd2, 32'h0, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t1_done_cyc", 64'(d_k), 64'(27));
        chk("t1_idle_cyc", 64'(i_k), 64'(28));
        chk("t1_rd_first", 64'(r_f), 64'(6));
        chk("t1_rd_n", 64'(r_n), 64'(2));
        chk("t1_err", 64'(e_k), -64'sd1);
        chk("t1_next", {32'd0, next_addr}, 64'h50);
        chk_image(idx0, 4'd3, 7'd2, 32'h0);

        // Same with stalls on header word 0x4 and E1 word 5 (0x44)
        idx0 = wlog.size();
        run(4'd3, 7'd2, 32'h0, 32'h4, 3, 32'h44, 2,
            d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t2_done_cyc", 64'(d_k), 64'(32));
        chk("t2_next", {32'd0, next_addr}, 64'h50);
        chk_image(idx0, 4'd3, 7'd2, 32'h0);

        // Empty table at 0x100
        idx0 = wlog.size();
        run(4'd7, 7'd0, 32'h100, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t3_done_cyc", 64'(d_k), 64'(7));
        chk("t3_rd_n", 64'(r_n), 64'(0));
        chk("t3_next", {32'd0, next_addr}, 64'h110);
        chk_image(idx0, 4'd7, 7'd0, 32'h100);

        // Rejects: too many entries, then misaligned base
        idx0 = wlog.size();
        run(4'd2, 7'd65, 32'h0, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t4_err_cyc", 64'(e_k), 64'(2));
        chk("t4_idle_cyc", 64'(i_k), 64'(3));
        chk("t4_we_n", 64'(w_n), 64'(0));
        chk("t4_done", 64'(d_k), -64'sd1);
        chk("t4_next", {32'd0, next_addr}, 64'h110);
        run(4'd2, 7'd2, 32'h102, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t5_err_cyc", 64'(e_k), 64'(2));
        chk("t5_idle_cyc", 64'(i_k), 64'(3));
        chk("t5_we_n", 64'(w_n), 64'(0));
        chk("t5_next", {32'd0, next_addr}, 64'h110);
        chk("t45_no_writes", 64'(wlog.size() - idx0), 0);

        // Boundary: exactly MAX entries accepted
        fill(8'h64);
        idx0 = wlog.size();
        run(4'd9, 7'd64, 32'h0, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t6_done_cyc", 64'(d_k), 64'(647));
        chk("t6_next", {32'd0, next_addr}, 64'h810);
        chk_image(idx0, 4'd9, 7'd64, 32'h0);

        // Chained image: A at 0 (N=1,id 1), B at next_addr (N=3,id 5)
        fill(8'hA1);
        run(4'd1, 7'd1, 32'h0, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("ta_done_cyc", 64'(d_k), 64'(17));
        chk("ta_next", {32'd0, next_addr}, 64'h30);
        fill(8'hB5);
        idx0 = wlog.size();
        run(4'd5, 7'd3, next_addr, 0, 0, 0, 0,
            d_k, e_k, i_k, r_f, r_n, w_n);
        chk("tb_done_cyc", 64'(d_k), 64'(37));
        chk("tb_next", {32'd0, next_addr}, 64'hA0);
        chk_image(idx0, 4'd5, 7'd3, 32'h30);
        @(negedge clk);
        chk("chain_overwrite", {32'd0, mem[12]}, 64'h44455354);
        chk("chain_term", {32'd0, mem[40]}, 0);
        p = 0; found = 0;
        for (int t = 0; t < 4 && found == 0; t++) begin
            if (mem[p/4] != 32'h44455354) break;
            cnt = int'(mem[p/4 + 1]);
            if (mem[p/4 + 2] == 32'd5) begin
                found = 1;
                chk("ld_count", 64'(cnt), 64'(3));
                for (int e = 0; e < 3; e++)
                    for (int w = 0; w < 8; w++)
                        chk("ld_word", {32'd0, mem[p/4 + 4 + 8*e + w]},
                            {32'd0, tbl[e][32*w +: 32]});
            end
            p = p + 16 + 32 * cnt;
        end
        chk("ld_found", 64'(found), 64'(1));

        // Reset while E0 word 4 is being written at 0x220
        fill(8'hC3);
        @(negedge clk);
        switch_id = 4'd6; entry_count = 7'd2; base_addr = 32'h200;
        start_write = 1'b1;
        @(negedge clk);
        start_write = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_we && mem_addr == 32'h220) break;
            @(negedge clk);
        end
        chk("rst_reach", {31'd0, mem_we, mem_addr}, {31'd0, 1'b1, 32'h220});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", {63'd0, mem_we}, 0);
        chk("rst_mid_busy", {63'd0, busy}, 0);
        chk("rst_mid_next", {32'd0, next_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idx0 = wlog.size();
        run(4'd6, 7'd2, 32'h200, 0, 0, 0, 0, d_k, e_k, i_k, r_f, r_n, w_n);
        chk("t7_done_cyc", 64'(d_k), 64'(27));
        chk("t7_next", {32'd0, next_addr}, 64'h250);
        chk_image(idx0, 4'd6, 7'd2, 32'h200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
